spi_adc_slave: RTL and testbench

SPI_ADC_SLAVE -- requirements
Module: spi_adc_slave

---
 rtl/spi_adc_slave_pkg.sv | 14 +
 rtl/spi_adc_slave_if.sv | 23 ++
 rtl/spi_adc_slave_sync_edge.sv | 33 +++
 rtl/spi_adc_slave.sv | 125 ++++++++++++
 tb/tb_spi_adc_slave.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_slave_pkg.sv
// Shared types and default constants for the SPI ADC slave.
package spi_adc_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LEAD_Z    = 3;
   localparam int unsigned FRAME_LEN = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/spi_adc_slave_if.sv
// SPI pins between the external master and the ADC slave.
interface spi_adc_slave_if;

   logic sclk;
   logic cs_n;
   logic sdata;
   logic sdata_oe;

   modport master (
      output sclk,
      output cs_n,
      input  sdata,
      input  sdata_oe
   );

   modport slave (
      input  sclk,
      input  cs_n,
      output sdata,
      output sdata_oe
   );

endinterface

// File: rtl/spi_adc_slave_sync_edge.sv
// Two-flop synchronizer plus a history flop.
// Produces single-clk rise and fall pulses.
module sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_hist;

   // Reset value matches the idle line level so reset release never looks like an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
         r_hist <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_hist;
   assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/spi_adc_slave.sv
// SPI slave that serialises a parallel ADC sample, MSB first.
// Leading and trailing zeros pad the sample out to a fixed frame length.
module spi_adc_slave #(
   parameter int unsigned DATA_W    = spi_adc_pkg::DATA_W,
   parameter int unsigned LEAD_Z    = spi_adc_pkg::LEAD_Z,
   parameter int unsigned FRAME_LEN = spi_adc_pkg::FRAME_LEN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    i_sample,
   spi_adc_slave_if.slave       io_spi,
   output logic                 o_busy,
   output logic                 o_frame_done,
   output logic                 o_abort
);

   import spi_adc_pkg::*;

   localparam int unsigned CNT_W   = $clog2(FRAME_LEN + 1);
   localparam int unsigned TRAIL_Z = FRAME_LEN - LEAD_Z - DATA_W;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [FRAME_LEN-1:0] r_shift;
   logic [FRAME_LEN-1:0] w_shift_nxt;
   logic [CNT_W-1:0]     r_count;
   logic [CNT_W-1:0]     w_count_nxt;
   logic                 r_frame_done;
   logic                 w_frame_done_nxt;
   logic                 r_abort;
   logic                 w_abort_nxt;
   logic [FRAME_LEN-1:0] w_load;

   logic w_sclk_fall;
   logic w_unused_sclk_rise;
   logic w_cs_fall;
   logic w_cs_rise;

   sync_edge #(
      .RESET_VAL (1'b0)
   ) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .i_async (io_spi.sclk),
      .o_rise  (w_unused_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   sync_edge #(
      .RESET_VAL (1'b1)
   ) u_sync_cs (
      .clk     (clk),
      .rst     (rst),
      .i_async (io_spi.cs_n),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   assign w_load = FRAME_LEN'(i_sample) << TRAIL_Z;

   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_count_nxt      = r_count;
      w_frame_done_nxt = 1'b0;
      w_abort_nxt      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = SHIFT;
               w_shift_nxt = w_load;
               w_count_nxt = '0;
            end
         end
         SHIFT: begin
            if (w_sclk_fall && r_count == CNT_W'(FRAME_LEN - 1)) begin
               // Final bit wins over a coincident cs_n rise, which then skips DONE
               w_frame_done_nxt = 1'b1;
               w_shift_nxt      = '0;
               w_count_nxt      = CNT_W'(FRAME_LEN);
               w_state_nxt      = w_cs_rise ? IDLE : DONE;
            end else if (w_cs_rise) begin
               w_abort_nxt = 1'b1;
               w_shift_nxt = '0;
               w_count_nxt = '0;
               w_state_nxt = IDLE;
            end else if (w_sclk_fall && r_count != CNT_W'(FRAME_LEN)) begin
               w_shift_nxt = {r_shift[FRAME_LEN-2:0], 1'b0};
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
         DONE: begin
            if (w_cs_rise) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_count      <= '0;
         r_frame_done <= 1'b0;
         r_abort      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_count      <= w_count_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_abort      <= w_abort_nxt;
      end
   end

   assign io_spi.sdata    = r_shift[FRAME_LEN-1];
   assign io_spi.sdata_oe = (r_state != IDLE);
   assign o_busy          = (r_state == SHIFT);
   assign o_frame_done    = r_frame_done;
   assign o_abort         = r_abort;

endmodule

// File: tb/tb_spi_adc_slave.sv
// Directed bench for spi_adc_slave: a behavioural SPI master clocks frames
// and checks captured bits, status pulses and reset behaviour.
module tb_spi_adc_slave;

   logic       clk;
   logic       rst;
   logic [7:0] sample;
   logic       busy;
   logic       frame_done;
   logic       abort;

   spi_adc_slave_if bus ();

   spi_adc_slave u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_sample     (sample),
      .io_spi       (bus),
      .o_busy       (busy),
      .o_frame_done (frame_done),
      .o_abort      (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_done  = 0;
   int n_abort = 0;

   always @(negedge clk) begin
      if (frame_done) n_done++;
      if (abort)      n_abort++;
   end

   typedef struct {
      logic [7:0]  smp;
      logic [15:0] bits;
      logic [3:0]  hi;
      logic [3:0]  lo;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] smp);
      sample   = smp;
      bus.cs_n = 1'b0;
      wait_clk(3);
      check("busy_at_start", {31'd0, busy}, 32'd1);
      check("oe_at_start", {31'd0, bus.sdata_oe}, 32'd1);
      wait_clk(7);
   endtask

   task automatic clock_bits(input int n, input int chg_at, input logic [7:0] chg_val,
                             output logic [31:0] bits);
      bits = '0;
      for (int b = 0; b < n; b++) begin
         if (b == chg_at) sample = chg_val;
         bus.sclk = 1'b1;
         bits = {bits[30:0], bus.sdata};
         wait_clk(10);
         bus.sclk = 1'b0;
         wait_clk(10);
      end
   endtask

   task automatic end_frame();
      bus.cs_n = 1'b1;
      wait_clk(3);
      check("oe_after_cs_rise", {31'd0, bus.sdata_oe}, 32'd0);
      wait_clk(5);
   endtask

   initial begin
      logic [31:0] bits;
      int d0;
      int a0;

      vecs[0] = '{smp: 8'hA5, bits: 16'h14A0, hi: 4'hA, lo: 4'h5};
      vecs[1] = '{smp: 8'h3C, bits: 16'h0780, hi: 4'h3, lo: 4'hC};
      vecs[2] = '{smp: 8'hFF, bits: 16'h1FE0, hi: 4'hF, lo: 4'hF};
      vecs[3] = '{smp: 8'h81, bits: 16'h1020, hi: 4'h8, lo: 4'h1};
      vecs[4] = '{smp: 8'h00, bits: 16'h0000, hi: 4'h0, lo: 4'h0};

      rst      = 1'b1;
      sample   = 8'h00;
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      wait_clk(3);
      check("rst_sdata", {31'd0, bus.sdata}, 32'd0);
      check("rst_oe", {31'd0, bus.sdata_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_abort", {31'd0, abort}, 32'd0);
      rst = 1'b0;
      wait_clk(6);
      check("release_no_edge", {30'd0, bus.sdata_oe, busy}, 32'd0);

      // sclk toggling with cs_n high must be ignored
      d0 = n_done;
      for (int i = 0; i < 4; i++) begin
         bus.sclk = 1'b1;
         wait_clk(5);
         bus.sclk = 1'b0;
         wait_clk(5);
      end
      check("idle_sclk_busy", {30'd0, bus.sdata_oe, busy}, 32'd0);
      check("idle_sclk_done", n_done - d0, 32'd0);

      for (int v = 0; v < 5; v++) begin
         d0 = n_done;
         a0 = n_abort;
         start_frame(vecs[v].smp);
         clock_bits(16, -1, 8'h00, bits);
         check("frame_bits", bits, {16'd0, vecs[v].bits});
         check("seg_h", {28'd0, bits[12:9]}, {28'd0, vecs[v].hi});
         check("seg_l", {28'd0, bits[8:5]}, {28'd0, vecs[v].lo});
         check("done_once", n_done - d0, 32'd1);
         check("done_state", {29'd0, busy, bus.sdata_oe, bus.sdata}, 32'b010);
         end_frame();
         check("no_abort", n_abort - a0, 32'd0);
      end

      // Abort after 6 bits, then a clean frame
      d0 = n_done;
      a0 = n_abort;
      start_frame(8'h5A);
      clock_bits(6, -1, 8'h00, bits);
      check("abort_bits", bits, 32'b000010);
      end_frame();
      check("abort_once", n_abort - a0, 32'd1);
      check("abort_no_done", n_done - d0, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      start_frame(8'hFF);
      clock_bits(16, -1, 8'h00, bits);
      check("after_abort_bits", bits, 32'h1FE0);
      end_frame();

      // Sample change mid-frame must not leak into the frame
      start_frame(8'h12);
      clock_bits(16, 4, 8'h34, bits);
      check("midchange_bits", bits, 32'h0240);
      end_frame();

      // 20 sclk edges in one window
      d0 = n_done;
      start_frame(8'hA5);
      clock_bits(20, -1, 8'h00, bits);
      check("extra_head", {16'd0, bits[19:4]}, 32'h14A0);
      check("extra_tail", {28'd0, bits[3:0]}, 32'd0);
      check("extra_done_once", n_done - d0, 32'd1);
      end_frame();

      // cs_n rise coincident with the final sclk fall: done wins, straight to IDLE
      d0 = n_done;
      a0 = n_abort;
      start_frame(8'hA5);
      clock_bits(15, -1, 8'h00, bits);
      bus.sclk = 1'b1;
      wait_clk(10);
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      wait_clk(3);
      check("coinc_oe", {31'd0, bus.sdata_oe}, 32'd0);
      wait_clk(4);
      check("coinc_done", n_done - d0, 32'd1);
      check("coinc_abort", n_abort - a0, 32'd0);

      // Reset at bit 9
      a0 = n_abort;
      start_frame(8'hC3);
      clock_bits(9, -1, 8'h00, bits);
      rst = 1'b1;
      #1;
      check("midrst_outs", {27'd0, bus.sdata, bus.sdata_oe, busy, frame_done, abort}, 32'd0);
      bus.cs_n = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(6);
      check("midrst_no_abort", n_abort - a0, 32'd0);
      check("midrst_idle", {30'd0, bus.sdata_oe, busy}, 32'd0);
      d0 = n_done;
      start_frame(8'h81);
      clock_bits(16, -1, 8'h00, bits);
      check("postrst_bits", bits, 32'h1020);
      check("postrst_done", n_done - d0, 32'd1);
      end_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
